// File: rtl/conv_pkg.sv
// Shared constants, datapath types and the round/saturate helpers for conv_window_mac.
// Pure package; no timing or flow-control behaviour of its own.
package conv_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int MAX_KERNEL_SIZE = 7;
  localparam int ACC_WIDTH       = 24;
  localparam int OUT_WIDTH       = 16;
  localparam int WIN_ELEMS       = MAX_KERNEL_SIZE * MAX_KERNEL_SIZE;
  localparam int PROD_WIDTH      = 2 * DATA_WIDTH + 1;
  localparam int K_WIDTH         = 3;
  localparam int SHIFT_WIDTH     = 4;
  localparam int ADDR_WIDTH      = 6;
  localparam int COUNT_WIDTH     = 16;

  typedef logic signed [DATA_WIDTH-1:0] weight_t;
  typedef logic signed [PROD_WIDTH-1:0] prod_t;
  typedef logic signed [ACC_WIDTH-1:0]  acc_t;
  typedef logic signed [ACC_WIDTH:0]    acc_ext_t;
  typedef logic signed [OUT_WIDTH-1:0]  out_t;

  // One extra bit of headroom so the rounding bias can never wrap the sum.
  function automatic acc_ext_t round_shift(input acc_t sum, input logic [SHIFT_WIDTH-1:0] shift);
    acc_ext_t ext;
    acc_ext_t bias;
    ext  = acc_ext_t'(sum);
    bias = '0;
    if (shift != '0)
      bias = acc_ext_t'(1) << (shift - 4'd1);
    return (ext + bias) >>> shift;
  endfunction

  function automatic out_t saturate(input acc_ext_t v);
    acc_ext_t hi;
    acc_ext_t lo;
    hi = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    lo = {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    if (v > hi)
      return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (v < lo)
      return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      return v[OUT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/conv_row_adder.sv
// Sums one row of MAX_KERNEL_SIZE signed products into a registered row sum.
// Latency 1 cycle; no flow control, always accepts a new row every cycle.
module conv_row_adder
  import conv_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  prod_t prods [MAX_KERNEL_SIZE],
  output acc_t  row_sum
);

  acc_t sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < MAX_KERNEL_SIZE; i++)
      sum = sum + ACC_WIDTH'(prods[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      row_sum <= '0;
    else
      row_sum <= sum;
  end

endmodule

// File: rtl/conv_window_mac.sv
// K x K window MAC with shadow/active kernel banks; CONV_MAC_RELU_EN clamps negative results to 0.
// Latency 4 cycles, 1 window/cycle; no backpressure (results must be consumed when valid).
module conv_window_mac
  import conv_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [K_WIDTH-1:0]                fu_kernel_size_in,
  input  logic [SHIFT_WIDTH-1:0]            fu_shift_in,
  input  logic [WIN_ELEMS*DATA_WIDTH-1:0]   fu_window_in,
  input  logic                              fu_window_valid_in,
  input  logic                              fu_weight_we_in,
  input  logic [ADDR_WIDTH-1:0]             fu_weight_addr_in,
  input  logic [DATA_WIDTH-1:0]             fu_weight_data_in,
  input  logic                              fu_weight_swap_in,
  output logic signed [OUT_WIDTH-1:0]       fu_result_out,
  output logic                              fu_result_valid_out,
  output logic [COUNT_WIDTH-1:0]            fu_result_count_out
);

  weight_t shadow [WIN_ELEMS];
  weight_t active [WIN_ELEMS];

  // Swap copies the shadow contents seen before this edge, so a same-cycle write stays in shadow only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_ELEMS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (fu_weight_we_in && (fu_weight_addr_in < ADDR_WIDTH'(WIN_ELEMS)))
        shadow[fu_weight_addr_in] <= fu_weight_data_in;
      if (fu_weight_swap_in)
        active <= shadow;
    end
  end

  logic [K_WIDTH-1:0]    k_eff;
  logic [ADDR_WIDTH-1:0] k_sq;
  prod_t                 prod_c [WIN_ELEMS];

  always_comb begin
    if (fu_kernel_size_in == '0)
      k_eff = K_WIDTH'(1);
    else if (int'(fu_kernel_size_in) > MAX_KERNEL_SIZE)
      k_eff = K_WIDTH'(MAX_KERNEL_SIZE);
    else
      k_eff = fu_kernel_size_in;
    k_sq = ADDR_WIDTH'(k_eff) * ADDR_WIDTH'(k_eff);
    for (int i = 0; i < WIN_ELEMS; i++) begin
      if (ADDR_WIDTH'(i) < k_sq)
        prod_c[i] = PROD_WIDTH'($signed({1'b0, fu_window_in[i*DATA_WIDTH +: DATA_WIDTH]}))
                  * PROD_WIDTH'(active[i]);
      else
        prod_c[i] = '0;
    end
  end

  // S1: masked products plus the shift that travels with this window.
  prod_t                   s1_prod [WIN_ELEMS];
  logic [SHIFT_WIDTH-1:0]  s1_shift;
  logic                    s1_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_ELEMS; i++)
        s1_prod[i] <= '0;
      s1_shift <= '0;
      s1_vld   <= 1'b0;
    end else begin
      s1_prod  <= prod_c;
      s1_shift <= fu_shift_in;
      s1_vld   <= fu_window_valid_in;
    end
  end

  // S2: row sums, flat element index grouped MAX_KERNEL_SIZE at a time.
  prod_t row_in  [MAX_KERNEL_SIZE][MAX_KERNEL_SIZE];
  acc_t  row_sum [MAX_KERNEL_SIZE];

  always_comb begin
    for (int r = 0; r < MAX_KERNEL_SIZE; r++)
      for (int c = 0; c < MAX_KERNEL_SIZE; c++)
        row_in[r][c] = s1_prod[r*MAX_KERNEL_SIZE + c];
  end

  for (genvar r = 0; r < MAX_KERNEL_SIZE; r++) begin : g_row
    conv_row_adder u_row (
      .clk     (clk),
      .rst_n   (rst_n),
      .prods   (row_in[r]),
      .row_sum (row_sum[r])
    );
  end

  logic [SHIFT_WIDTH-1:0] s2_shift;
  logic                   s2_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_shift <= '0;
      s2_vld   <= 1'b0;
    end else begin
      s2_shift <= s1_shift;
      s2_vld   <= s1_vld;
    end
  end

  // S3: total sum.
  acc_t                   total_c;
  acc_t                   s3_sum;
  logic [SHIFT_WIDTH-1:0] s3_shift;
  logic                   s3_vld;

  always_comb begin
    total_c = '0;
    for (int r = 0; r < MAX_KERNEL_SIZE; r++)
      total_c = total_c + row_sum[r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_sum   <= '0;
      s3_shift <= '0;
      s3_vld   <= 1'b0;
    end else begin
      s3_sum   <= total_c;
      s3_shift <= s2_shift;
      s3_vld   <= s2_vld;
    end
  end

  // S4: round, shift, saturate, optional ReLU; result holds between valid cycles.
  out_t res_c;

  always_comb begin
    res_c = saturate(round_shift(s3_sum, s3_shift));
`ifdef CONV_MAC_RELU_EN
    if (res_c[OUT_WIDTH-1])
      res_c = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_result_out       <= '0;
      fu_result_valid_out <= 1'b0;
      fu_result_count_out <= '0;
    end else begin
      fu_result_valid_out <= s3_vld;
      if (s3_vld)
        fu_result_out <= res_c;
      if (fu_weight_swap_in)
        fu_result_count_out <= '0;
      else if (s3_vld)
        fu_result_count_out <= fu_result_count_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: stimulus pushes expected results, a negedge monitor pops and checks.
// Honours CONV_MAC_RELU_EN when computing expected values.
module tb_conv_window_mac;
  import conv_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst_n;
  logic [K_WIDTH-1:0]               fu_kernel_size_in;
  logic [SHIFT_WIDTH-1:0]           fu_shift_in;
  logic [WIN_ELEMS*DATA_WIDTH-1:0]  fu_window_in;
  logic                             fu_window_valid_in;
  logic                             fu_weight_we_in;
  logic [ADDR_WIDTH-1:0]            fu_weight_addr_in;
  logic [DATA_WIDTH-1:0]            fu_weight_data_in;
  logic                             fu_weight_swap_in;
  logic signed [OUT_WIDTH-1:0]      fu_result_out;
  logic                             fu_result_valid_out;
  logic [COUNT_WIDTH-1:0]           fu_result_count_out;

  conv_window_mac dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fu_kernel_size_in   (fu_kernel_size_in),
    .fu_shift_in         (fu_shift_in),
    .fu_window_in        (fu_window_in),
    .fu_window_valid_in  (fu_window_valid_in),
    .fu_weight_we_in     (fu_weight_we_in),
    .fu_weight_addr_in   (fu_weight_addr_in),
    .fu_weight_data_in   (fu_weight_data_in),
    .fu_weight_swap_in   (fu_weight_swap_in),
    .fu_result_out       (fu_result_out),
    .fu_result_valid_out (fu_result_valid_out),
    .fu_result_count_out (fu_result_count_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int    val;
    int    due;
    string name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [WIN_ELEMS*DATA_WIDTH-1:0] win;

  task automatic check(input string name, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && fu_result_valid_out) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0d at cycle %0d, expected no result", fu_result_out, cyc);
      end else begin
        mon_e = sbq.pop_front();
        check({mon_e.name, "_value"}, int'(fu_result_out), mon_e.val);
        check({mon_e.name, "_latency"}, cyc, mon_e.due);
      end
    end
  end

  function automatic int relu(input int v);
`ifdef CONV_MAC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic fill_win(input int v);
    for (int i = 0; i < WIN_ELEMS; i++)
      win[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(v);
  endtask

  task automatic set_el(input int i, input int v);
    win[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(v);
  endtask

  task automatic send(input int k, input int sh, input bit push, input int expv, input string name);
    fu_kernel_size_in  = K_WIDTH'(k);
    fu_shift_in        = SHIFT_WIDTH'(sh);
    fu_window_in       = win;
    fu_window_valid_in = 1'b1;
    if (push)
      sbq.push_back('{val: expv, due: cyc + 4, name: name});
    tick();
    fu_window_valid_in = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    fu_weight_we_in   = 1'b1;
    fu_weight_addr_in = ADDR_WIDTH'(a);
    fu_weight_data_in = DATA_WIDTH'(d);
    tick();
    fu_weight_we_in   = 1'b0;
  endtask

  task automatic swap();
    fu_weight_swap_in = 1'b1;
    tick();
    fu_weight_swap_in = 1'b0;
  endtask

  int lap [9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};

  initial begin
    rst_n              = 1'b0;
    fu_kernel_size_in  = '0;
    fu_shift_in        = '0;
    fu_window_in       = '0;
    fu_window_valid_in = 1'b0;
    fu_weight_we_in    = 1'b0;
    fu_weight_addr_in  = '0;
    fu_weight_data_in  = '0;
    fu_weight_swap_in  = 1'b0;
    win                = '0;
    idle(3);
    check("reset_result", int'(fu_result_out), 0);
    check("reset_valid", int'(fu_result_valid_out), 0);
    check("reset_count", int'(fu_result_count_out), 0);
    rst_n = 1'b1;
    tick();

    // Box filter over 1..9, plain and with rounding shift.
    for (int i = 0; i < 9; i++) wr(i, 1);
    swap();
    fill_win(0);
    for (int i = 0; i < 9; i++) set_el(i, i + 1);
    send(3, 0, 1, 45, "t1_sum");
    send(3, 2, 1, 11, "t1_shift2");

    // Laplacian kernel.
    for (int i = 0; i < 9; i++) wr(i, lap[i]);
    swap();
    fill_win(0);
    for (int i = 0; i < 9; i++) set_el(i, 200);
    send(3, 0, 1, 0, "t2_flat");
    fill_win(0);
    set_el(4, 255);
    send(3, 0, 1, 1020, "t2_centre");
    send(3, 4, 1, 64, "t2_centre_sh4");
    fill_win(0);
    set_el(1, 3); set_el(3, 3); set_el(5, 3); set_el(7, 3);
    send(3, 3, 1, relu(-1), "t2_neg_round");
    idle(6);
    check("count_after_t2", int'(fu_result_count_out), 4);

    // Saturation at full 7x7.
    for (int i = 0; i < WIN_ELEMS; i++) wr(i, 127);
    swap();
    fill_win(255);
    send(7, 0, 1, 32767, "t3_pos_sat");
    for (int i = 0; i < WIN_ELEMS; i++) wr(i, -128);
    swap();
    send(7, 0, 1, relu(-32768), "t3_neg_sat");

    // K=2 with junk above element 3; K=0 behaves as K=1.
    for (int i = 0; i < WIN_ELEMS; i++) wr(i, (i < 4) ? i + 1 : 100);
    swap();
    fill_win(255);
    set_el(0, 10); set_el(1, 20); set_el(2, 30); set_el(3, 40);
    send(2, 0, 1, 300, "t4_k2_masked");
    send(0, 0, 1, 10, "t4_k0_as_k1");
    idle(6);

    // Swap mid-stream, write+swap in the same cycle, swap beating an increment.
    for (int i = 0; i < 4; i++) wr(i, 2);
    fill_win(255);
    for (int i = 0; i < 4; i++) set_el(i, 1);
    send(2, 0, 1, 10, "t5_pre_swap");
    fu_kernel_size_in  = 3'd2;
    fu_shift_in        = '0;
    fu_window_in       = win;
    fu_window_valid_in = 1'b1;
    fu_weight_swap_in  = 1'b1;
    fu_weight_we_in    = 1'b1;
    fu_weight_addr_in  = '0;
    fu_weight_data_in  = 8'd7;
    sbq.push_back('{val: 10, due: cyc + 4, name: "t5_at_swap"});
    tick();
    fu_window_valid_in = 1'b0;
    fu_weight_swap_in  = 1'b0;
    fu_weight_we_in    = 1'b0;
    send(2, 0, 1, 8, "t5_post_swap");
    idle(6);
    check("count_after_swap_stream", int'(fu_result_count_out), 3);
    send(2, 0, 1, 8, "t5_x");
    idle(2);
    swap();
    check("count_swap_wins", int'(fu_result_count_out), 0);
    send(2, 0, 1, 13, "t5_new_shadow");
    idle(6);
    check("count_after_new_shadow", int'(fu_result_count_out), 1);

    // Reset with three windows in flight.
    fill_win(255);
    send(7, 0, 0, 0, "t6_flight");
    send(7, 0, 0, 0, "t6_flight");
    send(7, 0, 0, 0, "t6_flight");
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(6);
    check("t6_result_after_reset", int'(fu_result_out), 0);
    check("t6_valid_after_reset", int'(fu_result_valid_out), 0);
    check("t6_count_after_reset", int'(fu_result_count_out), 0);
    send(7, 0, 1, 0, "t6_active_zero");
    swap();
    send(7, 0, 1, 0, "t6_shadow_zero");
    idle(8);

    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
